// File: rtl/cache_axi_arbiter.sv
// Round-robin arbiter funnelling whole-line cache loads/stores onto one AXI4 master, one burst in flight.
// Load latency: accept N, arvalid N+1, bus_valid the cycle after rlast; no new grant until completion is taken.
module cache_axi_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 64,
    parameter int CHUNKS_LOG  = 3,
    parameter int CONNECTIONS = 4,
    localparam int LINE = DATA_WIDTH * (2 ** CHUNKS_LOG),
    localparam int ID_W = $clog2(CONNECTIONS)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [CONNECTIONS-1:0]            command_valid,
    input  logic [CONNECTIONS-1:0]            command_store,
    input  logic [CONNECTIONS*ADDR_WIDTH-1:0] command_addr,
    input  logic [CONNECTIONS*LINE-1:0]       data_in,
    output logic [CONNECTIONS-1:0]            bus_ready,
    output logic [CONNECTIONS-1:0]            bus_valid,
    input  logic [CONNECTIONS-1:0]            command_ready,
    output logic [ID_W-1:0]                   cacheID,
    output logic [LINE-1:0]                   data_out,
    output logic                              bus_err,
    output logic [ADDR_WIDTH-1:0]             m_axi_araddr,
    output logic [7:0]                        m_axi_arlen,
    output logic [2:0]                        m_axi_arsize,
    output logic [1:0]                        m_axi_arburst,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [DATA_WIDTH-1:0]             m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rlast,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready,
    output logic [ADDR_WIDTH-1:0]             m_axi_awaddr,
    output logic [7:0]                        m_axi_awlen,
    output logic [2:0]                        m_axi_awsize,
    output logic [1:0]                        m_axi_awburst,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [DATA_WIDTH-1:0]             m_axi_wdata,
    output logic                              m_axi_wlast,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready
);
    localparam int BEATS    = 2 ** CHUNKS_LOG;
    localparam int OFF_BITS = $clog2(LINE / 8);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] L_ADDR  = 3'd1;
    localparam logic [2:0] L_READ  = 3'd2;
    localparam logic [2:0] S_ADDR  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    localparam logic [CHUNKS_LOG-1:0] LAST_BEAT = CHUNKS_LOG'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH - OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};

    logic [2:0]            state;
    logic [ID_W-1:0]       id;
    logic [ID_W-1:0]       last_id;
    logic [ID_W-1:0]       grant_id;
    logic [CONNECTIONS-1:0] grant;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE-1:0]       line;
    logic [CHUNKS_LOG-1:0] beat;
    logic                  accept;

    // Scan from the highest priority offset down so the last hit is the first requester after last_id.
    always_comb begin
        int idx;
        idx      = 0;
        grant    = '0;
        grant_id = '0;
        for (int k = CONNECTIONS - 1; k >= 0; k--) begin
            idx = (int'(last_id) + 1 + k) % CONNECTIONS;
            if (command_valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

    assign bus_ready = (state == IDLE && reset_n) ? grant : '0;
    assign accept    = |(command_valid & bus_ready);
    assign bus_valid = (state == DONE) ? (CONNECTIONS'(1) << id) : '0;
    assign cacheID   = id;

    assign m_axi_araddr  = addr;
    assign m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (state == L_ADDR);
    assign m_axi_rready  = (state == L_READ);
    assign m_axi_awaddr  = addr;
    assign m_axi_awlen   = 8'(BEATS - 1);
    assign m_axi_awsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = (state == S_ADDR);
    assign m_axi_wvalid  = (state == S_WRITE);
    assign m_axi_wdata   = line[beat*DATA_WIDTH +: DATA_WIDTH];
    assign m_axi_wlast   = (state == S_WRITE) && (beat == LAST_BEAT);
    assign m_axi_bready  = (state == S_RESP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            id       <= '0;
            last_id  <= ID_W'(CONNECTIONS - 1);
            addr     <= '0;
            line     <= '0;
            beat     <= '0;
            data_out <= '0;
            bus_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    id      <= grant_id;
                    addr    <= command_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH] & LINE_MASK;
                    bus_err <= 1'b0;
                    beat    <= '0;
                    if (command_store[grant_id]) begin
                        line  <= data_in[grant_id*LINE +: LINE];
                        state <= S_ADDR;
                    end else begin
                        state <= L_ADDR;
                    end
                end
                L_ADDR: if (m_axi_arready) state <= L_READ;
                L_READ: if (m_axi_rvalid) begin
                    data_out[beat*DATA_WIDTH +: DATA_WIDTH] <= m_axi_rdata;
                    beat <= beat + 1'b1;
                    if (m_axi_rresp != 2'b00) bus_err <= 1'b1;
                    // rlast out of step with the beat count ends the burst as an error either way.
                    if (m_axi_rlast || beat == LAST_BEAT) begin
                        state <= DONE;
                        if (m_axi_rlast != (beat == LAST_BEAT)) bus_err <= 1'b1;
                    end
                end
                S_ADDR: if (m_axi_awready) begin
                    state <= S_WRITE;
                    beat  <= '0;
                end
                S_WRITE: if (m_axi_wready) begin
                    beat <= beat + 1'b1;
                    if (beat == LAST_BEAT) state <= S_RESP;
                end
                S_RESP: if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) bus_err <= 1'b1;
                    state <= DONE;
                end
                DONE: if (command_ready[id]) begin
                    last_id <= id;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
